clk_div_sched: RTL and testbench

- Run-time programmable clock-divider controller: sequences a single-edge divide-by-N counter and generates a divided output plus a one-cycle tick per output period.
- Accepts new divide ratios over a valid/ready handshake and applies them only on output-period boundaries, so clk_out never glitches.
- Supports a clean stop: the current period finishes, then the output parks low.
- Used as the shared, configurable replacement for the fixed-ratio dividers in the clocking/timing section.

---
 rtl/clk_div_sched.sv | 137 +++++++++++++
 tb/tb_clk_div_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// clk_div_sched: run-time programmable divide-by-N clock generator.
// A single up-counter (cnt) walks 0..cur_div-1 per output period. clk_out is
// high for the first floor(N/2) cycles of each period, and tick marks cnt==0.
// A new ratio is taken over a valid/ready handshake. While running, it is held
// in pend_div and swapped in only on a period boundary, so clk_out never glitches.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; cnt=0, clk_out parked low, new ratios load directly
// RUN   | en high; counting and toggling clk_out every period
// DRAIN | en dropped; finish the current period, then park in IDLE
module clk_div_sched #(
  parameter int W       = 8,
  parameter int DEF_DIV = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         clk_out,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] cur_div,
  output logic         cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   cnt, cnt_nxt;
  logic [W-1:0]   cur_div_nxt;
  logic [W-1:0]   pend_div, pend_div_nxt;
  logic           pend, pend_nxt;
  logic           clk_out_nxt, tick_nxt, busy_nxt, cfg_err_nxt;
  logic           running_nxt;
  logic           xfer, xfer_legal, boundary;

  // A ratio is only taken when nothing is pending; reset blocks transfers.
  assign cfg_ready  = !pend && !rst;
  assign xfer       = cfg_valid && cfg_ready;
  assign xfer_legal = xfer && (cfg_div >= W'(2));
  // Last cycle of the current period; the wrap compare uses the latched ratio.
  assign boundary   = (state != ST_IDLE) && (cnt == cur_div - W'(1));

  // Next-state, counter, ratio bookkeeping and registered-output decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_div_nxt  = cur_div;
    pend_nxt     = pend;
    pend_div_nxt = pend_div;
    cfg_err_nxt  = xfer && !xfer_legal;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        // A ratio left pending when the divider stopped lands here; cfg_ready
        // is low meanwhile, so it cannot collide with a direct load.
        if (pend) begin
          cur_div_nxt = pend_div;
          pend_nxt    = 1'b0;
        end else if (xfer_legal) begin
          cur_div_nxt = cfg_div;
        end
        if (en) state_nxt = ST_RUN;
      end

      ST_RUN, ST_DRAIN: begin
        if (boundary) begin
          cnt_nxt = '0;
          if (pend) begin
            cur_div_nxt = pend_div;
            pend_nxt    = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + W'(1);
        end
        // xfer implies pend==0, so this never overlaps the apply above; a
        // transfer on the boundary cycle waits for the following boundary.
        if (xfer_legal) begin
          pend_div_nxt = cfg_div;
          pend_nxt     = 1'b1;
        end
        if (state == ST_RUN) begin
          if (!en) state_nxt = ST_DRAIN;
        end else begin
          if (en)            state_nxt = ST_RUN;
          else if (boundary) state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are decoded from the next cycle's state so they come straight
    // out of flops and line up with cnt/cur_div in the same cycle.
    running_nxt = (state_nxt != ST_IDLE);
    clk_out_nxt = running_nxt && (cnt_nxt < (cur_div_nxt >> 1));
    tick_nxt    = running_nxt && (cnt_nxt == '0);
    busy_nxt    = running_nxt;
  end

  // State, counter, ratio and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur_div  <= W'(DEF_DIV);
      pend_div <= W'(DEF_DIV);
      pend     <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      busy     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_div  <= cur_div_nxt;
      pend_div <= pend_div_nxt;
      pend     <= pend_nxt;
      clk_out  <= clk_out_nxt;
      tick     <= tick_nxt;
      busy     <= busy_nxt;
      cfg_err  <= cfg_err_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Testbench for clk_div_sched: per-cycle expected {tick, clk_out, busy, cur_div}
// words are queued as stimulus is planned and popped as each cycle is observed.
module tb_clk_div_sched;
  localparam int W       = 8;
  localparam int DEF_DIV = 5;

  logic         clk = 1'b0;
  logic         rst, en, cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready, clk_out, tick, busy, cfg_err;
  logic [W-1:0] cur_div;

  int checks = 0;
  int errors = 0;
  logic [W+2:0] exp_q[$];   // {tick, clk_out, busy, cur_div}

  clk_div_sched #(.W(W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .clk_out(clk_out), .tick(tick), .busy(busy),
    .cur_div(cur_div), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are observed at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W+2:0] obs();
    return {tick, clk_out, busy, cur_div};
  endfunction

  task automatic push_cycle(input logic t, input logic c, input logic b, input int d);
    exp_q.push_back({t, c, b, W'(d)});
  endtask

  task automatic push_period(input int n);
    for (int i = 0; i < n; i++) push_cycle(i == 0, i < n / 2, 1'b1, n);
  endtask

  task automatic push_idle(input int n, input int d);
    for (int i = 0; i < n; i++) push_cycle(1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    cyc(); cyc();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [W+2:0] e;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    push_idle(3, DEF_DIV);
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL reset_outputs cyc %0d: got %h expected %h", i, obs(), e);
      end
      checks++;
      if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
        errors++; $display("FAIL reset_ready cyc %0d: got ready=%b err=%b expected 0 0", i, cfg_ready, cfg_err);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", cfg_ready);
    end
    push_idle(1, DEF_DIV);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL reset_idle: got %h ready=%b expected %h ready=1", obs(), cfg_ready, e);
    end
  endtask

  task automatic test_default_run();
    logic [W+2:0] e;
    do_reset();
    en = 1'b1;
    for (int p = 0; p < 3; p++) push_period(5);
    for (int i = 0; i < 15; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL default_run cyc %0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_ratio_change();
    logic [W+2:0] e;
    logic         exp_rdy;
    do_reset();
    en = 1'b1;
    push_period(5); push_period(4); push_period(4);
    for (int i = 0; i < 13; i++) begin
      cfg_valid = (i == 2);   // sampled at the edge ending the cnt=1 cycle
      cfg_div   = 8'd4;
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL ratio_change cyc %0d: got %h expected %h", i, obs(), e);
      end
      exp_rdy = !(i >= 2 && i <= 4);
      checks++;
      if (cfg_ready !== exp_rdy) begin
        errors++; $display("FAIL ratio_change_ready cyc %0d: got %b expected %b", i, cfg_ready, exp_rdy);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_illegal();
    logic [W+2:0] e;
    logic         exp_err;
    do_reset();
    en = 1'b1;
    for (int p = 0; p < 3; p++) push_period(5);
    for (int i = 0; i < 15; i++) begin
      cfg_valid = (i == 3 || i == 7);
      cfg_div   = (i == 3) ? 8'd1 : 8'd0;
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL illegal_wave cyc %0d: got %h expected %h", i, obs(), e);
      end
      exp_err = (i == 3 || i == 7);
      checks++;
      if (cfg_err !== exp_err || cfg_ready !== 1'b1) begin
        errors++; $display("FAIL illegal_err cyc %0d: got err=%b ready=%b expected err=%b ready=1",
                           i, cfg_err, cfg_ready, exp_err);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [W+2:0] e;
    do_reset();
    // en drops while cnt=2: period finishes (cnt 3,4), then IDLE.
    push_period(5); push_idle(3, 5);
    for (int i = 0; i < 8; i++) begin
      en = (i < 3);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL drain cyc %0d: got %h expected %h", i, obs(), e);
      end
    end
    // en drops at cnt=1 and returns at cnt=3: waveform must be seamless.
    push_period(5); push_period(5);
    for (int i = 0; i < 10; i++) begin
      en = !(i == 2 || i == 3);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL reenable cyc %0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [W+2:0] e;
    do_reset();
    en = 1'b1;
    push_cycle(1'b1, 1'b1, 1'b1, 5);
    push_cycle(1'b0, 1'b1, 1'b1, 5);
    push_idle(1, 5);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL rst_pend_start: got %h expected %h", obs(), e);
    end
    cfg_valid = 1'b1; cfg_div = 8'd7;
    cyc();
    cfg_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL rst_pend_held: got %h ready=%b expected %h ready=0", obs(), cfg_ready, e);
    end
    rst = 1'b1;
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL rst_pend_reset: got %h ready=%b expected %h ready=0", obs(), cfg_ready, e);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL rst_pend_cleared: got ready=%b expected 1", cfg_ready);
    end
    push_period(5); push_period(5);
    for (int i = 0; i < 10; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL rst_pend_restart cyc %0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+2:0] e;
    logic         exp_rdy;
    do_reset();
    // Legal ratio loaded directly in IDLE without en.
    cfg_valid = 1'b1; cfg_div = 8'd2; en = 1'b0;
    push_idle(1, 2);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL idle_load: got %h ready=%b expected %h ready=1", obs(), cfg_ready, e);
    end
    // Load 3 together with en, then offer 6 on the boundary cycle of period one.
    push_period(3); push_period(3); push_period(6); push_period(6);
    for (int i = 0; i < 18; i++) begin
      en        = 1'b1;
      cfg_valid = (i == 0 || i == 3);
      cfg_div   = (i == 0) ? 8'd3 : 8'd6;
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL back_to_back cyc %0d: got %h expected %h", i, obs(), e);
      end
      exp_rdy = !(i >= 3 && i <= 5);
      checks++;
      if (cfg_ready !== exp_rdy) begin
        errors++; $display("FAIL back_to_back_ready cyc %0d: got %b expected %b", i, cfg_ready, exp_rdy);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_max_ratio();
    logic [W+2:0] e;
    do_reset();
    push_period(255); push_period(2); push_period(2);
    for (int i = 0; i < 259; i++) begin
      en        = 1'b1;
      cfg_valid = (i == 0 || i == 10);
      cfg_div   = (i == 0) ? 8'd255 : 8'd2;
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL max_ratio cyc %0d: got %h expected %h", i, obs(), e);
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_ratio_change();
    test_illegal();
    test_drain();
    test_reset_pending();
    test_back_to_back();
    test_max_ratio();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
